regfile_sb: RTL

Parametrised register file for the pipelined RISC-V core. It adds to the single-cycle register file:
- a configurable number of combinational read ports;
- x0 hardwired to zero;
- write-to-read bypass;
- asynchronous clear;
- a per-register pending-write scoreboard, so decode can detect RAW hazards and stall.

It sits between decode (reads, issue) and writeback (write port).

---
 rtl/rv_pkg.sv | 18 +
 rtl/regfile_pend_cnt.sv | 42 ++++
 rtl/regfile_sb.sv | 81 ++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and helpers for the RISC-V core register file
package rv_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int REG_ZERO = 0;

  // Ceiling log2, used to size register addresses from the register count.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_pend_cnt.sv
// rtl/regfile_pend_cnt.sv - saturating up/down pending-write counter for one register
module regfile_pend_cnt #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [PW-1:0] cnt_o,
  output logic          is_max_o,
  output logic          is_one_o
);

  logic [PW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, simultaneous inc/dec cancel, both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + PW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - PW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign is_max_o = (cnt_q == '1);
  assign is_one_o = (cnt_q == PW'(1));

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with bypass and pending-write scoreboard
module regfile_sb
  import rv_pkg::*;
#(
  parameter int  XLEN = DEF_XLEN,
  parameter int  NREG = DEF_NREG,
  parameter int  NRP  = 2,
  parameter int  PW   = 2,
  localparam int AW   = log2c(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRP*AW-1:0] ra_i,
  output logic [NRP*XLEN-1:0] rd_o,
  output logic [NRP-1:0]    rbusy_o,
  input  logic              we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [XLEN-1:0]   wd_i,
  input  logic              iss_i,
  input  logic [AW-1:0]     iss_rd_i,
  output logic              iss_rdy_o,
  input  logic              flush_i
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [PW-1:0]   cnt   [NREG];
  logic [NREG-1:0] is_max;
  logic [NREG-1:0] is_one;
  logic [NREG-1:1] inc;
  logic [NREG-1:1] dec;
  logic            iss_eff;

  // x0 carries no counter; it always looks idle.
  assign cnt[0]    = '0;
  assign is_max[0] = 1'b0;
  assign is_one[0] = 1'b0;

  // A full counter can still accept an issue when writeback frees a slot this cycle.
  assign iss_rdy_o = (iss_rd_i == AW'(REG_ZERO)) || !is_max[iss_rd_i] ||
                     (we_i && (wa_i == iss_rd_i));
  assign iss_eff   = iss_i && iss_rdy_o && !flush_i && (iss_rd_i != AW'(REG_ZERO));

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    assign inc[r] = iss_eff && (iss_rd_i == AW'(r));
    assign dec[r] = we_i && (wa_i == AW'(r));

    regfile_pend_cnt #(.PW(PW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (inc[r]),
      .dec_i    (dec[r]),
      .clr_i    (flush_i),
      .cnt_o    (cnt[r]),
      .is_max_o (is_max[r]),
      .is_one_o (is_one[r])
    );
  end

  // Writeback into the array; x0 is never written so it holds its reset zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else if (we_i && (wa_i != AW'(REG_ZERO))) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Combinational read ports with same-cycle writeback bypass.
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp;

    assign a   = ra_i[p*AW +: AW];
    assign byp = we_i && (wa_i == a);
    assign rd_o[p*XLEN +: XLEN] = (a == AW'(REG_ZERO)) ? '0 :
                                  byp                  ? wd_i : mem_q[a];
    // Last outstanding write completing now clears the hazard in the same cycle.
    assign rbusy_o[p] = (a != AW'(REG_ZERO)) && (cnt[a] != '0) && !(byp && is_one[a]);
  end

endmodule
